// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg: shared multiply/divide opcodes, default latencies and FSM state type.
package md_sequencer_pkg;
    localparam int MD_OP_W = 3;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF = 10;
    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;
    typedef enum logic {IDLE, RUN} md_state_e;
endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: E-stage request bus and HI/LO/busy return to the multiply/divide sequencer.
interface md_sequencer_if;
    import md_sequencer_pkg::*;
    logic               start;
    logic [MD_OP_W-1:0] md_op;
    logic [31:0]        a;
    logic [31:0]        b;
    logic               flush;
    logic               busy;
    logic [31:0]        hi;
    logic [31:0]        lo;
    modport master (output start, md_op, a, b, flush, input busy, hi, lo);
    modport slave  (input start, md_op, a, b, flush, output busy, hi, lo);
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational signed/unsigned 32x32 product and quotient/remainder.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic [MD_OP_W-1:0] op,
    output logic [31:0]        hi_r,
    output logic [31:0]        lo_r,
    output logic               div0
);
    logic [63:0] sp, up;
    logic [31:0] ma, mb, ud, mq, mr, uq, ur, sq, sr;
    logic        bz;
    always_comb begin
        sp = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        up = {32'd0, a} * {32'd0, b};
        bz = b == 32'd0;
        ud = bz ? 32'd1 : b;
        // Signed division on magnitudes so 0x80000000 / -1 wraps cleanly
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : ud;
        mq = ma / mb;
        mr = ma % mb;
        sq = (a[31] ^ b[31]) ? -mq : mq;
        sr = a[31] ? -mr : mr;
        uq = a / ud;
        ur = a % ud;
        div0 = op[2:1] == 2'b01 && bz;
        hi_r = op == MD_MULT ? sp[63:32] : op == MD_MULTU ? up[63:32] : op == MD_DIV ? sr : ur;
        lo_r = op == MD_MULT ? sp[31:0] : op == MD_MULTU ? up[31:0] : op == MD_DIV ? sq : uq;
    end
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div controller owning HI/LO; results commit when the latency counter expires.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input logic           clk,
    input logic           reset,
    md_sequencer_if.slave bus
);
    md_state_e   state;
    logic [CNT_W-1:0] cnt;
    logic [31:0] hi_s, lo_s, hi_r, lo_r;
    logic        div0_s, div0;
    md_arith u_arith (
        .a   (bus.a),
        .b   (bus.b),
        .op  (bus.md_op),
        .hi_r(hi_r),
        .lo_r(lo_r),
        .div0(div0)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bus.busy <= 1'b0;
            bus.hi <= '0;
            bus.lo <= '0;
            hi_s   <= '0;
            lo_s   <= '0;
            div0_s <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start && !bus.flush) begin
                if (!bus.md_op[2]) begin
                    hi_s     <= hi_r;
                    lo_s     <= lo_r;
                    div0_s   <= div0;
                    cnt      <= bus.md_op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
                    bus.busy <= 1'b1;
                    state    <= RUN;
                end else if (bus.md_op == MD_MTHI) begin
                    bus.hi <= bus.a;
                end else if (bus.md_op == MD_MTLO) begin
                    bus.lo <= bus.a;
                end
            end
        end else if (bus.flush || cnt == CNT_W'(1)) begin
            // A flush abandons the shadow result; normal completion commits it unless divisor was zero
            if (!bus.flush && !div0_s) begin
                bus.hi <= hi_s;
                bus.lo <= lo_s;
            end
            cnt      <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed test-plan sequences plus random traffic against a transaction-level HI/LO model.
module tb_md_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] p_res = '0;
    logic        p_ok = 1'b0;
    int          left = 0;

    md_sequencer_if bus ();
    md_sequencer dut (.clk(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin q = sa * sb; return q; end
            3'd1: begin pu = ua * ub; return pu; end
            3'd2: begin
                if (sb == 0) return '0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (ub == 0) return '0;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic cyc(input logic s = 0, input logic [2:0] op = 0, input logic [31:0] a = 0,
                       input logic [31:0] b = 0, input logic f = 0, input logic r = 0);
        rst = r;
        bus.start = s;
        bus.md_op = op;
        bus.a = a;
        bus.b = b;
        bus.flush = f;
        if (s && !r) chk("no_start_while_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        if (r) begin
            m_hi = '0; m_lo = '0; left = 0;
        end else if (left > 0) begin
            if (f) left = 0;
            else begin
                left--;
                if (left == 0 && p_ok) {m_hi, m_lo} = p_res;
            end
        end else if (s && !f) begin
            if (op < 3'd4) begin
                p_res = ref_md(op, a, b);
                p_ok = !(op >= 3'd2 && b == 32'd0);
                left = op >= 3'd2 ? 10 : 5;
            end else if (op == 3'd4) m_hi = a;
            else if (op == 3'd5) m_lo = a;
        end
        @(negedge clk);
        chk("busy", {31'd0, bus.busy}, {31'd0, left > 0});
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
    endtask

    initial begin
        bus.start = 0; bus.md_op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 1);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        cyc(1, 0, 32'hFFFFFFFD, 5);
        repeat (4) cyc();
        chk("mult_busy5", {31'd0, bus.busy}, 32'd1);
        cyc();
        chk("mult_done", {31'd0, bus.busy}, 32'd0);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFF1);
        cyc(1, 1, 32'hFFFFFFFD, 5);
        repeat (5) cyc();
        chk("multu_hi", bus.hi, 32'h00000004);
        chk("multu_lo", bus.lo, 32'hFFFFFFF1);
        cyc(1, 2, 32'hFFFFFFF9, 2);
        repeat (9) cyc();
        chk("div_busy10", {31'd0, bus.busy}, 32'd1);
        cyc();
        chk("div_hi", bus.hi, 32'hFFFFFFFF);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        cyc(1, 2, 32'h80000000, 32'hFFFFFFFF);
        repeat (10) cyc();
        chk("divovf_hi", bus.hi, 32'h0);
        chk("divovf_lo", bus.lo, 32'h80000000);
        cyc(1, 4, 32'h12345678);
        chk("mthi_hi", bus.hi, 32'h12345678);
        cyc(1, 5, 32'h9ABCDEF0);
        chk("mtlo_lo", bus.lo, 32'h9ABCDEF0);
        cyc(1, 3, 7, 0);
        repeat (10) cyc();
        chk("div0_hi", bus.hi, 32'h12345678);
        chk("div0_lo", bus.lo, 32'h9ABCDEF0);
        cyc(1, 0, 3, 4);
        cyc();
        cyc(0, 0, 0, 0, 1);
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        repeat (6) cyc();
        chk("flush_lo", bus.lo, 32'h9ABCDEF0);
        cyc(1, 5, 32'hDEADBEEF, 0, 1);
        chk("flush_mtlo", bus.lo, 32'h9ABCDEF0);
        cyc(1, 2, 100, 3);
        cyc(); cyc();
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_hi", bus.hi, 32'd0);
        cyc(1, 1, 2, 3);
        repeat (5) cyc();
        chk("multu_lo6", bus.lo, 32'd6);
        chk("multu_hi0", bus.hi, 32'd0);
        for (int i = 0; i < 3000; i++) begin
            logic s, f, r;
            logic [2:0] op;
            logic [31:0] a, b;
            r = $urandom_range(0, 199) == 0;
            s = left == 0 && $urandom_range(0, 2) == 0;
            f = $urandom_range(0, 24) == 0;
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 9));
            if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            cyc(s, op, a, b, f, r);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
